// File: rtl/bcd_countdown_if.sv
// Control and display signals of the two-digit BCD countdown timer.
interface bcd_countdown_if;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       done;
    logic [1:0] state;

    modport master (
        output load, load_val, start, pause,
        input  tens, ones, running, done, state
    );

    modport slave (
        input  load, load_val, start, pause,
        output tens, ones, running, done, state
    );
endinterface

// File: rtl/bcd_countdown.sv
// Two-digit BCD countdown timer with a prescaler, pause/resume and a
// one-cycle done pulse when the value reaches 00.
module bcd_countdown #(
    parameter int unsigned TICK_DIV = 1
) (
    input logic            clk,
    input logic            reset,
    bcd_countdown_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic [7:0] presc_q;
    logic       done_q;

    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic       value_zero;
    logic       advance;
    logic       tick;
    logic       last_tick;

    // Load clamping and tick qualification.
    always_comb begin
        load_tens  = (bus.load_val[7:4] > 4'd9) ? 4'd9 : bus.load_val[7:4];
        load_ones  = (bus.load_val[3:0] > 4'd9) ? 4'd9 : bus.load_val[3:0];
        value_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
        advance    = (state_q == RUN) && !bus.pause && !bus.load;
        tick       = advance && (presc_q == PRESC_LAST);
        last_tick  = tick && (tens_q == 4'd0) && (ones_q == 4'd1);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; load overrides everything, pause beats start.
    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (bus.start) state_d = value_zero ? DONE : RUN;
                RUN: begin
                    if (bus.pause)
                        state_d = PAUSE;
                    else if (last_tick)
                        state_d = DONE;
                end
                PAUSE: if (!bus.pause && bus.start) state_d = RUN;
                DONE:  state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Digit, prescaler and done-pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_q  <= '0;
            ones_q  <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                tens_q  <= load_tens;
                ones_q  <= load_ones;
                presc_q <= '0;
            end else begin
                if ((state_q == IDLE) && bus.start && value_zero)
                    done_q <= 1'b1;
                if (advance) begin
                    if (tick) begin
                        presc_q <= '0;
                        if (!value_zero) begin
                            if (ones_q == 4'd0) begin
                                ones_q <= 4'd9;
                                tens_q <= tens_q - 4'd1;
                            end else begin
                                ones_q <= ones_q - 4'd1;
                            end
                        end
                        if (last_tick)
                            done_q <= 1'b1;
                    end else begin
                        presc_q <= presc_q + 8'd1;
                    end
                end
            end
        end
    end

    // Output drive; running is decoded directly from the state.
    always_comb begin
        bus.running = (state_q == RUN);
        bus.state   = state_q;
        bus.tens    = tens_q;
        bus.ones    = ones_q;
        bus.done    = done_q;
    end

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: two instances (TICK_DIV=1 and 3) driven in
// lockstep and compared against an integer-valued behavioural model.
module tb_bcd_countdown;

    logic clk;
    logic reset;

    bcd_countdown_if if1();
    bcd_countdown_if if3();

    bcd_countdown #(.TICK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    bcd_countdown #(.TICK_DIV(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    int checks = 0;
    int fails  = 0;

    // Model: value as an integer 0..99, state code 0..3, prescaler count.
    int m_val [2];
    int m_st  [2];
    int m_pre [2];
    bit m_done[2];
    int div   [2] = '{1, 3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input bit ld, input logic [7:0] lv, input bit st, input bit pa);
        if1.load = ld; if1.load_val = lv; if1.start = st; if1.pause = pa;
        if3.load = ld; if3.load_val = lv; if3.start = st; if3.pause = pa;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_st[k] = 0; m_pre[k] = 0; m_done[k] = 1'b0;
        end
    endfunction

    function automatic void model_step(int k, bit ld, logic [7:0] lv, bit st, bit pa);
        int t;
        int o;
        m_done[k] = 1'b0;
        if (ld) begin
            t = (lv[7:4] > 9) ? 9 : int'(lv[7:4]);
            o = (lv[3:0] > 9) ? 9 : int'(lv[3:0]);
            m_val[k] = t * 10 + o;
            m_st[k]  = 0;
            m_pre[k] = 0;
        end else if (m_st[k] == 0) begin
            if (st) begin
                if (m_val[k] == 0) begin m_st[k] = 3; m_done[k] = 1'b1; end
                else m_st[k] = 1;
            end
        end else if (m_st[k] == 1) begin
            if (pa) m_st[k] = 2;
            else if (m_pre[k] == div[k] - 1) begin
                m_pre[k] = 0;
                m_val[k] = m_val[k] - 1;
                if (m_val[k] == 0) begin m_st[k] = 3; m_done[k] = 1'b1; end
            end else m_pre[k] = m_pre[k] + 1;
        end else if (m_st[k] == 2) begin
            if (!pa && st) m_st[k] = 1;
        end
    endfunction

    // Advance model and DUTs by one edge; sample 1 time unit after it.
    task automatic step();
        for (int k = 0; k < 2; k++)
            model_step(k, if1.load, if1.load_val, if1.start, if1.pause);
        @(posedge clk);
        #1;
    endtask

    // {running, done, state, tens, ones}
    function automatic logic [11:0] exp_vec(int k);
        logic [1:0] s;
        logic [3:0] t;
        logic [3:0] o;
        s = 2'(m_st[k]);
        t = 4'(m_val[k] / 10);
        o = 4'(m_val[k] % 10);
        return {m_st[k] == 1, m_done[k], s, t, o};
    endfunction

    function automatic logic [11:0] act_vec(int k);
        if (k == 0) return {if1.running, if1.done, if1.state, if1.tens, if1.ones};
        return {if3.running, if3.done, if3.state, if3.tens, if3.ones};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 8'h00, 0, 0);
        #3;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_vec(k) !== exp_vec(k)) begin
                fails++;
                $display("FAIL reset k=%0d got=%h exp=%h", k, act_vec(k), exp_vec(k));
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_count_12();
        int done_cnt;
        int first_done;
        done_cnt = 0;
        first_done = -1;
        set_in(1, 8'h12, 0, 0); step();
        set_in(0, 8'h00, 1, 0); step();
        set_in(0, 8'h00, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (if1.done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL count12 k=%0d cyc=%0d got=%h exp=%h", k, i, act_vec(k), exp_vec(k));
                end
            end
        end
        checks++;
        if (done_cnt !== 1 || first_done !== 11) begin
            fails++;
            $display("FAIL count12_done_pulse got=%0d@%0d exp=1@11", done_cnt, first_done);
        end
        checks++;
        if (if3.state !== 2'b11) begin
            fails++;
            $display("FAIL count12_div3_final got=%b exp=11", if3.state);
        end
    endtask

    task automatic test_div3();
        int run_cyc;
        run_cyc = 0;
        set_in(1, 8'h02, 0, 0); step();
        set_in(0, 8'h00, 1, 0); step();
        if (if3.running === 1'b1) run_cyc++;
        set_in(0, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (if3.running === 1'b1) run_cyc++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL div3 k=%0d cyc=%0d got=%h exp=%h", k, i, act_vec(k), exp_vec(k));
                end
            end
        end
        checks++;
        if (run_cyc !== 6) begin
            fails++;
            $display("FAIL div3_run_cycles got=%0d exp=6", run_cyc);
        end
    endtask

    task automatic test_pause();
        set_in(1, 8'h20, 0, 0); step();
        set_in(0, 8'h00, 1, 0); step();
        set_in(0, 8'h00, 0, 0); step();
        checks++;
        if ({if1.tens, if1.ones} !== 8'h19) begin
            fails++;
            $display("FAIL pause_first_tick got=%h exp=19", {if1.tens, if1.ones});
        end
        for (int i = 0; i < 7; i++) begin
            if (i < 4) set_in(0, 8'h00, 0, 1);
            else if (i == 4) set_in(0, 8'h00, 1, 0);
            else set_in(0, 8'h00, 0, 0);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL pause k=%0d cyc=%0d got=%h exp=%h", k, i, act_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_clamp_zero();
        set_in(1, 8'hFC, 0, 0); step();
        checks++;
        if ({if1.tens, if1.ones} !== 8'h99) begin
            fails++;
            $display("FAIL clamp got=%h exp=99", {if1.tens, if1.ones});
        end
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: set_in(1, 8'h00, 0, 0);
                1: set_in(0, 8'h00, 1, 0);
                2: set_in(0, 8'h00, 0, 0);
                default: set_in(0, 8'h00, 1, 1);
            endcase
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL zero_start k=%0d cyc=%0d got=%h exp=%h", k, i, act_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        set_in(1, 8'h48, 0, 0); step();
        set_in(0, 8'h00, 1, 0); step();
        set_in(0, 8'h00, 0, 0); step();
        checks++;
        if ({if1.tens, if1.ones} !== 8'h47) begin
            fails++;
            $display("FAIL async_pre got=%h exp=47", {if1.tens, if1.ones});
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_vec(k) !== exp_vec(k)) begin
                fails++;
                $display("FAIL async_reset k=%0d got=%h exp=%h", k, act_vec(k), exp_vec(k));
            end
        end
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL async_after k=%0d cyc=%0d got=%h exp=%h", k, i, act_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_combo();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: set_in(1, 8'h30, 0, 0);
                1: set_in(0, 8'h00, 1, 0);
                2: set_in(0, 8'h00, 0, 1);
                3: set_in(0, 8'h00, 1, 1);
                4: set_in(1, 8'h00, 0, 0);
                5: set_in(0, 8'h00, 1, 0);
                6: set_in(1, 8'h55, 1, 0);
                default: set_in(0, 8'h00, 0, 0);
            endcase
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL combo k=%0d cyc=%0d got=%h exp=%h", k, i, act_vec(k), exp_vec(k));
                end
            end
        end
        checks++;
        if ({if1.state, if1.running, if1.tens, if1.ones} !== {2'b00, 1'b0, 8'h55}) begin
            fails++;
            $display("FAIL combo_load_start got=%b/%b/%h exp=00/0/55", if1.state, if1.running, {if1.tens, if1.ones});
        end
    endtask

    task automatic test_random();
        bit         ld;
        bit         st;
        bit         pa;
        logic [7:0] lv;
        for (int i = 0; i < 600; i++) begin
            ld = ($urandom % 25) == 0;
            lv = 8'($urandom);
            st = ($urandom % 3) == 0;
            pa = ($urandom % 8) == 0;
            set_in(ld, lv, st, pa);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL random k=%0d cyc=%0d got=%h exp=%h", k, i, act_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_12();
        test_div3();
        test_pause();
        test_clamp_zero();
        test_async_reset();
        test_combo();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/bcd_countdown.md
BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1: clocks per count step; legal range 1..255.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load  input  1  synchronous load strobe.
REQ-005 SHALL have port load_val  input  8  preset value; [7:4] tens BCD, [3:0] ones BCD.
REQ-006 SHALL have port start  input  1  begin or resume counting.
REQ-007 SHALL have port pause  input  1  suspend counting.
REQ-008 SHALL have port tens  output  4  tens digit, 8421 BCD, registered.
REQ-009 SHALL have port ones  output  4  ones digit, 8421 BCD, registered.
REQ-010 SHALL have port running  output  1  high while state is RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse on reaching 00.
REQ-012 SHALL have port state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-013 SHALL implement the four states IDLE, RUN, PAUSE and DONE.
REQ-014 SHALL give load top priority in every state: capture load_val into tens/ones, enter IDLE, clear prescaler, done=0.
REQ-015 SHALL clamp each loaded digit greater than 9 to 9, per digit (load_val 8'hA3 gives 93).
REQ-016 SHALL, on start in IDLE with value not equal to 00, enter RUN at the next edge.
REQ-017 SHALL, on start in IDLE with value 00, enter DONE and pulse done for one cycle.
REQ-018 SHALL, in RUN, increment the prescaler each cycle through 0..TICK_DIV-1; at TICK_DIV-1 a tick occurs and the prescaler returns to 0.
REQ-019 SHALL, on each tick, decrement the value by one in BCD.
REQ-020 SHALL make the ones digit go from 0 to 9 with a borrow that decrements tens; otherwise ones decrements.
REQ-021 SHALL, on the tick that takes the value from 01 to 00, update value, state=DONE and done=1 on the same edge.
REQ-022 SHALL never produce a value below 00 and never produce a non-BCD digit.
REQ-023 SHALL, on pause in RUN, enter PAUSE at the next edge with value and prescaler held; no tick occurs on that edge.
REQ-024 SHALL give pause priority over start when both are asserted in RUN or PAUSE.
REQ-025 SHALL, on start (without pause) in PAUSE, enter RUN and resume from the held prescaler count.
REQ-026 SHALL hold 00 in DONE; start and pause are ignored; only load leaves DONE.
REQ-027 SHALL deassert done after exactly one cycle, even if DONE persists.
REQ-028 SHALL ignore start in RUN and pause in IDLE.
REQ-029 SHALL treat load with start in the same cycle as load only; start must be reasserted.
REQ-030 SHALL drive running combinationally from state==RUN.

Reset
REQ-031 SHALL, when reset is asserted, immediately set tens=0, ones=0, state=IDLE, done=0, running=0 and prescaler=0, regardless of clk.
REQ-032 SHALL, on reset mid-RUN, abort counting; no done pulse is generated.
REQ-033 SHALL begin normal operation on the first clk edge after reset deasserts.

Verification
REQ-034 SHALL cover: TICK_DIV=1, load 8'h12, start -> values 11,10,09,...,01,00 on successive edges; done high exactly one cycle with the 00 edge; state=11.
REQ-035 SHALL cover: TICK_DIV=3, load 8'h02, start -> value changes every 3rd cycle in RUN; 00 after 6 RUN cycles.
REQ-036 SHALL cover: load 8'h20, run one tick -> 19; pause 4 cycles, value holds 19, state=10; start -> resumes 18.
REQ-037 SHALL cover: load 8'hFC -> tens=9, ones=9; load 8'h00 then start -> DONE with one done pulse, no RUN cycle.
REQ-038 SHALL cover: reset asserted asynchronously mid-count at 47 -> outputs 00, IDLE, done=0, before the next clk edge.
REQ-039 SHALL cover: start and pause together in PAUSE -> stays PAUSE; load and start together in DONE -> IDLE with loaded value, running=0.
